// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding RAM reads into a prefetch FIFO,
// presented with decoded fields over valid/ready; supports branch flush, grant back-off and halt.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        Enable,
    output logic        RW,
    output logic [15:0] Address,
    input  logic [31:0] Out,
    input  logic        mem_grant,
    input  logic        halt,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [15:0] pc_out,
    output logic [3:0]  Cond,
    output logic [3:0]  OpCode,
    output logic        S,
    output logic [3:0]  destination,
    output logic [3:0]  source_2,
    output logic [3:0]  source_1,
    output logic [4:0]  IV
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, STALL, HALTED} state_t;
    state_t state;

    logic [15:0]      pc;
    logic [15:0]      last_addr;
    logic             inflight;
    logic [31:0]      fifo_word [DEPTH];
    logic [15:0]      fifo_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             issue;
    logic             push;
    logic             pop;
    logic             go_stall;

    // Grant is sampled in the issue cycle itself, so the request strobe is
    // decoded from the registered state plus this cycle's grant/halt/branch.
    // A branch cycle never issues: the redirected fetch starts the cycle after.
    assign issue = ((state == FETCH) || (state == STALL)) && !halt && !branch_en &&
                   mem_grant && !inflight && (count < FULL);
    assign push  = inflight && !branch_en;
    assign pop   = inst_valid && inst_ready;

    assign Enable  = issue;
    assign RW      = 1'b0;
    assign Address = issue ? pc : last_addr;

    assign inst_valid  = (count != '0);
    assign instruction = fifo_word[rd_ptr];
    assign pc_out      = fifo_pc[rd_ptr];
    assign Cond        = instruction[31:28];
    assign OpCode      = instruction[27:24];
    assign S           = instruction[23];
    assign destination = instruction[22:19];
    assign source_2    = instruction[18:15];
    assign source_1    = instruction[14:11];
    assign IV          = instruction[10:6];

    always_comb begin
        count_n = '0;
        if (!branch_en) begin
            count_n = count + CNT_W'(push) - CNT_W'(pop);
        end
        go_stall = ((count_n + CNT_W'(issue)) == FULL) || !mem_grant;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            last_addr <= RESET_PC;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_word[PTR_W'(i)] <= '0;
                fifo_pc[PTR_W'(i)]   <= '0;
            end
        end else begin
            inflight <= issue;
            count    <= count_n;
            if (issue) begin
                last_addr <= pc;
                pc        <= pc + 16'd1;
            end
            // The response of a request in flight during a branch arrives in
            // the branch cycle itself, so skipping the push drops it.
            if (branch_en) begin
                pc     <= branch_target;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_word[wr_ptr] <= Out;
                    fifo_pc[wr_ptr]   <= last_addr;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (halt) begin
                state <= HALTED;
            end else begin
                case (state)
                    IDLE, HALTED: state <= FETCH;
                    default:      state <= go_stall ? STALL : FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector tables for the startup stream and
// branch flush, hand sequences for backpressure, grant loss, wrap, halt and reset.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable, RW;
    logic [15:0] Address;
    logic [31:0] Out;
    logic        mem_grant = 1'b1, halt = 1'b0, branch_en = 1'b0, inst_ready = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [15:0] pc_out;
    logic [3:0]  Cond, OpCode, destination, source_2, source_1;
    logic        S;
    logic [4:0]  IV;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .RW(RW), .Address(Address), .Out(Out),
        .mem_grant(mem_grant), .halt(halt), .branch_en(branch_en), .branch_target(branch_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .pc_out(pc_out),
        .Cond(Cond), .OpCode(OpCode), .S(S), .destination(destination), .source_2(source_2),
        .source_1(source_1), .IV(IV)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        case (a)
            16'h0000: return 32'hAAAAAAAA;
            16'h0001: return 32'hABBBAAAA;
            16'h0002: return 32'hCCCC00AA;
            16'h0003: return 32'hDDDD00BB;
            default:  return {~a, a};
        endcase
    endfunction

    // RAM: data for an Enable cycle appears on Out during the following cycle
    always @(posedge Clk) begin
        if (Enable) Out <= ram_word(Address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic g, input logic h, input logic r, input logic be,
                        input logic [15:0] bt);
        @(negedge Clk);
        mem_grant = g; halt = h; inst_ready = r; branch_en = be; branch_target = bt;
        #1;
    endtask

    typedef struct {
        logic        g, h, r, be;
        logic [15:0] bt;
        logic        ca;
        logic        en;
        logic [15:0] addr;
        logic        cv;
        logic        v;
        logic [15:0] pc;
        logic        fld;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic g, h, r, be, input logic [15:0] bt,
                                input logic ca, en, input logic [15:0] addr,
                                input logic cv, v, input logic [15:0] pc, input logic fld);
        vec_t x;
        x.g = g; x.h = h; x.r = r; x.be = be; x.bt = bt;
        x.ca = ca; x.en = en; x.addr = addr; x.cv = cv; x.v = v; x.pc = pc; x.fld = fld;
        return x;
    endfunction

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            step(vecs[i].g, vecs[i].h, vecs[i].r, vecs[i].be, vecs[i].bt);
            check($sformatf("%s[%0d].Enable", tag, i), Enable, vecs[i].en);
            if (vecs[i].ca) check($sformatf("%s[%0d].Address", tag, i), Address, vecs[i].addr);
            if (vecs[i].cv) check($sformatf("%s[%0d].inst_valid", tag, i), inst_valid, vecs[i].v);
            if (vecs[i].cv && vecs[i].v) begin
                check($sformatf("%s[%0d].pc_out", tag, i), pc_out, vecs[i].pc);
                check($sformatf("%s[%0d].instruction", tag, i), instruction, ram_word(vecs[i].pc));
            end
            if (vecs[i].fld) begin
                check("field.Cond", Cond, 4'hA);
                check("field.OpCode", OpCode, 4'hB);
                check("field.S", S, 1'b1);
                check("field.destination", destination, 4'h7);
                check("field.source_2", source_2, 4'h7);
                check("field.source_1", source_1, 4'h5);
                check("field.IV", IV, 5'h0A);
            end
        end
    endtask

    task automatic stream(input string tag, input logic [15:0] start, input int n,
                          input int off_lo, input int off_hi, input int exp_words);
        logic [15:0] ea, ep;
        logic        g;
        int          got;
        step(1'b1, 1'b0, 1'b1, 1'b1, start);
        ea = start; ep = start; got = 0;
        for (int c = 1; c <= n; c++) begin
            g = !(c >= off_lo && c <= off_hi);
            step(g, 1'b0, 1'b1, 1'b0, 16'h0000);
            if (!g) check({tag, ".no_enable"}, Enable, 1'b0);
            if (Enable) begin
                check({tag, ".addr"}, Address, ea);
                ea = ea + 16'd1;
            end
            if (inst_valid) begin
                check({tag, ".pc_out"}, pc_out, ep);
                check({tag, ".word"}, instruction, ram_word(ep));
                ep = ep + 16'd1;
                got++;
            end
        end
        check({tag, ".words"}, got, exp_words);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".Enable"}, Enable, 1'b0);
        check({tag, ".RW"}, RW, 1'b0);
        check({tag, ".Address"}, Address, 16'h0000);
        check({tag, ".inst_valid"}, inst_valid, 1'b0);
        check({tag, ".instruction"}, instruction, 32'h0);
        check({tag, ".pc_out"}, pc_out, 16'h0000);
        check({tag, ".fields"}, {Cond, OpCode, S, destination, source_2, source_1, IV}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, got, found;

        // Reset state
        @(negedge Clk); #1;
        check_reset_outputs("reset");
        @(negedge Clk);
        Reset = 1'b0; inst_ready = 1'b1;
        #1;
        check("idle.Enable", Enable, 1'b0);

        // Startup stream: one request / one word every two cycles
        vecs = {};
        vecs.push_back(mk(1,0,1,0,16'h0, 1,1,16'h0000, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,1,0,16'h0, 1,0,16'h0000, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,1,0,16'h0, 1,1,16'h0001, 1,1,16'h0000, 0));
        vecs.push_back(mk(1,0,1,0,16'h0, 1,0,16'h0001, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,1,0,16'h0, 1,1,16'h0002, 1,1,16'h0001, 1));
        vecs.push_back(mk(1,0,1,0,16'h0, 1,0,16'h0002, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,1,0,16'h0, 1,1,16'h0003, 1,1,16'h0002, 0));
        vecs.push_back(mk(1,0,1,0,16'h0, 1,0,16'h0003, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,1,0,16'h0, 1,1,16'h0004, 1,1,16'h0003, 0));
        run_vecs("start");

        // Backpressure: FIFO fills to DEPTH, then drains without loss
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010);
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
            if (Enable) pulses++;
            if (c >= 9) check("full.no_enable", Enable, 1'b0);
        end
        check("full.pulses", pulses, DEPTH);
        check("full.valid", inst_valid, 1'b1);
        check("full.head_pc", pc_out, 16'h0010);
        got = 0;
        for (int c = 0; c < 40 && got < DEPTH + 1; c++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
            if (inst_valid) begin
                check("drain.pc_out", pc_out, 32'h10 + got);
                check("drain.word", instruction, ram_word(16'(16'h0010 + got)));
                got++;
            end
        end
        check("drain.count", got, DEPTH + 1);

        // Branch with two buffered words and one request in flight
        vecs = {};
        vecs.push_back(mk(1,0,0,1,16'h0020, 0,0,16'h0000, 0,0,16'h0000, 0));
        vecs.push_back(mk(1,0,0,0,16'h0000, 1,1,16'h0020, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,0,0,16'h0000, 1,0,16'h0020, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,0,0,16'h0000, 1,1,16'h0021, 1,1,16'h0020, 0));
        vecs.push_back(mk(1,0,0,0,16'h0000, 1,0,16'h0021, 1,1,16'h0020, 0));
        vecs.push_back(mk(1,0,0,0,16'h0000, 1,1,16'h0022, 1,1,16'h0020, 0));
        vecs.push_back(mk(1,0,0,1,16'h0008, 1,0,16'h0022, 1,1,16'h0020, 0));
        vecs.push_back(mk(1,0,0,0,16'h0000, 1,1,16'h0008, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,0,0,16'h0000, 1,0,16'h0008, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,1,0,16'h0000, 1,1,16'h0009, 1,1,16'h0008, 0));
        vecs.push_back(mk(1,0,1,0,16'h0000, 1,0,16'h0009, 1,0,16'h0000, 0));
        vecs.push_back(mk(1,0,1,0,16'h0000, 1,1,16'h000A, 1,1,16'h0009, 0));
        run_vecs("branch");

        // Grant withdrawn for five cycles mid-stream, then address wrap
        stream("grant", 16'h0040, 20, 4, 8, 7);
        stream("wrap", 16'hFFFE, 8, 100, 0, 3);

        // Branch while halted: redirect only, fetch resumes after halt drops
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0050);
        for (int c = 1; c <= 5; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
            check("halt.no_enable", Enable, 1'b0);
            check("halt.no_valid", inst_valid, 1'b0);
        end
        found = 0;
        for (int c = 0; c < 4 && found == 0; c++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
            if (Enable) begin
                found = 1;
                check("halt.resume_addr", Address, 16'h0050);
            end
        end
        check("halt.resume", found, 1);

        // Asynchronous reset with a word buffered and a request in flight
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0030);
        for (int c = 1; c <= 6; c++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("prereset.valid", inst_valid, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("restart.idle", Enable, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("restart.Enable", Enable, 1'b1);
        check("restart.Address", Address, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("restart.valid", inst_valid, 1'b1);
        check("restart.pc_out", pc_out, 16'h0000);
        check("restart.word", instruction, 32'hAAAAAAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
